// File: rtl/sdio_cia_pkg.sv
// Shared definitions for the SDIO function-0 CIA access sequencer.
// The optional read-after-write states exist only when SDIO_CIA_RAW_EN is defined.
package sdio_cia_pkg;

  // Region bases within the 17-bit CIA byte space
  localparam logic [16:0] CCCR_BASE        = 17'h00000;
  localparam logic [16:0] FBR_STRIDE       = 17'h00100;
  localparam logic [16:0] CIS_BASE_DEFAULT = 17'h01000;
  localparam logic [16:0] CIS_SIZE_DEFAULT = 17'h01000;

  // Access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3
`ifdef SDIO_CIA_RAW_EN
    ,
    ST_RAW_ISSUE = 3'd4,
    ST_RAW_WAIT  = 3'd5
`endif
  } cia_state_t;

endpackage

// File: rtl/sdio_cia_decode.sv
// Combinational CIA address decoder: maps a byte address onto the CCCR, one
// of the per-function FBRs or the CIS window, and produces the target offset.
// Writes into the CIS window are flagged as errors (the CIS is read-only).
module sdio_cia_decode
  import sdio_cia_pkg::*;
#(
  parameter int          NUM_FUNCS = 7,
  parameter logic [16:0] CIS_BASE  = CIS_BASE_DEFAULT,
  parameter logic [16:0] CIS_SIZE  = CIS_SIZE_DEFAULT
) (
  input  logic [16:0]          addr,
  input  logic                 write,
  output logic                 cccr_sel,
  output logic [NUM_FUNCS-1:0] fbr_sel,
  output logic                 cis_sel,
  output logic                 err,
  output logic [16:0]          offset
);

  // One bit wider so a window touching the top of the space cannot wrap
  localparam logic [17:0] CIS_END = {1'b0, CIS_BASE} + {1'b0, CIS_SIZE};

  logic                 cccr_hit;
  logic [NUM_FUNCS-1:0] fbr_hit;
  logic                 cis_hit;

  assign cccr_hit = (addr[16:8] == CCCR_BASE[16:8]);

  // FBR n occupies one 256-byte page at n * stride
  generate
    for (genvar gi = 0; gi < NUM_FUNCS; gi++) begin : g_fbr
      localparam logic [16:0] FBR_N_BASE = FBR_STRIDE * 17'(gi + 1);
      assign fbr_hit[gi] = (addr[16:8] == FBR_N_BASE[16:8]);
    end
  endgenerate

  assign cis_hit = ({1'b0, addr} >= {1'b0, CIS_BASE}) && ({1'b0, addr} < CIS_END);

  // Register pages win over the CIS window; anything unmatched is an error
  always_comb begin
    cccr_sel = cccr_hit;
    fbr_sel  = fbr_hit;
    cis_sel  = 1'b0;
    err      = 1'b0;
    offset   = {9'd0, addr[7:0]};
    if (!cccr_hit && (fbr_hit == '0)) begin
      if (cis_hit && !write) begin
        cis_sel = 1'b1;
        offset  = addr - CIS_BASE;
      end else begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdio_cia_ctrl.sv
// CMD52 single-byte access sequencer into the function-0 CIA register space.
// Latches one command, strobes the decoded target, waits its read latency and
// returns exactly one completion. Define SDIO_CIA_RAW_EN to build the
// read-after-write path (second read strobe after a RAW write).
module sdio_cia_ctrl
  import sdio_cia_pkg::*;
#(
  parameter int          NUM_FUNCS    = 7,
  parameter int          READ_LATENCY = 1,
  parameter logic [16:0] CIS_BASE     = CIS_BASE_DEFAULT,
  parameter logic [16:0] CIS_SIZE     = CIS_SIZE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_stb,
  input  logic                   i_cmd_write,
  input  logic                   i_cmd_raw,
  input  logic [16:0]            i_cmd_addr,
  input  logic [7:0]             i_cmd_data,
  output logic                   o_cmd_busy,
  output logic                   o_cmd_done,
  output logic                   o_cmd_err,
  output logic [7:0]             o_cmd_data,
  output logic                   o_cccr_activate,
  output logic [NUM_FUNCS-1:0]   o_fbr_activate,
  output logic                   o_cis_activate,
  output logic                   o_tgt_write,
  output logic                   o_tgt_stb,
  output logic [16:0]            o_tgt_addr,
  output logic [7:0]             o_tgt_data,
  input  logic [7:0]             i_cccr_data,
  input  logic [8*NUM_FUNCS-1:0] i_fbr_data,
  input  logic [7:0]             i_cis_data
);

  // Countdown start so WAIT lasts exactly READ_LATENCY cycles
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  cia_state_t           state_reg, state_next;
  logic                 write_reg;
  logic                 cccr_sel_reg;
  logic [NUM_FUNCS-1:0] fbr_sel_reg;
  logic                 cis_sel_reg;
  logic [16:0]          addr_reg;
  logic [7:0]           wdata_reg;
  logic [1:0]           wait_cnt_reg;
  logic                 err_reg;
  logic [7:0]           rdata_reg;

  logic                 dec_cccr;
  logic [NUM_FUNCS-1:0] dec_fbr;
  logic                 dec_cis;
  logic                 dec_err;
  logic [16:0]          dec_offset;

  logic                 act_en;
  logic                 capture;
  logic [7:0]           tgt_rdata;
  logic [7:0]           fbr_masked [NUM_FUNCS];

`ifdef SDIO_CIA_RAW_EN
  logic                 raw_reg;
`else
  logic                 unused_raw;
  assign unused_raw = i_cmd_raw;
`endif

  sdio_cia_decode #(
    .NUM_FUNCS (NUM_FUNCS),
    .CIS_BASE  (CIS_BASE),
    .CIS_SIZE  (CIS_SIZE)
  ) u_decode (
    .addr     (i_cmd_addr),
    .write    (i_cmd_write),
    .cccr_sel (dec_cccr),
    .fbr_sel  (dec_fbr),
    .cis_sel  (dec_cis),
    .err      (dec_err),
    .offset   (dec_offset)
  );

  // Only the selected FBR may contribute to the read-back byte
  generate
    for (genvar gi = 0; gi < NUM_FUNCS; gi++) begin : g_fbr_mux
      assign fbr_masked[gi] = fbr_sel_reg[gi] ? i_fbr_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // AND-OR read mux over the latched one-hot target select
  always_comb begin
    tgt_rdata = (cccr_sel_reg ? i_cccr_data : 8'h00) | (cis_sel_reg ? i_cis_data : 8'h00);
    for (int i = 0; i < NUM_FUNCS; i++) begin
      tgt_rdata = tgt_rdata | fbr_masked[i];
    end
  end

  // Next-state and per-state strobe/activate/handshake outputs
  always_comb begin
    state_next  = state_reg;
    act_en      = 1'b0;
    capture     = 1'b0;
    o_tgt_stb   = 1'b0;
    o_tgt_write = 1'b0;
    o_cmd_busy  = 1'b1;
    o_cmd_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_cmd_busy = 1'b0;
        if (i_cmd_stb) state_next = dec_err ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        act_en      = 1'b1;
        o_tgt_stb   = 1'b1;
        o_tgt_write = write_reg;
        if (!write_reg) state_next = ST_WAIT;
`ifdef SDIO_CIA_RAW_EN
        else if (raw_reg) state_next = ST_RAW_ISSUE;
`endif
        else state_next = ST_DONE;
      end
      ST_WAIT: begin
        act_en  = 1'b1;
        capture = (wait_cnt_reg == 2'd0);
        if (capture) state_next = ST_DONE;
      end
`ifdef SDIO_CIA_RAW_EN
      ST_RAW_ISSUE: begin
        act_en     = 1'b1;
        o_tgt_stb  = 1'b1;
        state_next = ST_RAW_WAIT;
      end
      ST_RAW_WAIT: begin
        act_en  = 1'b1;
        capture = (wait_cnt_reg == 2'd0);
        if (capture) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_cmd_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_cccr_activate = cccr_sel_reg & act_en;
  assign o_fbr_activate  = fbr_sel_reg & {NUM_FUNCS{act_en}};
  assign o_cis_activate  = cis_sel_reg & act_en;
  assign o_tgt_addr      = addr_reg;
  assign o_tgt_data      = wdata_reg;
  assign o_cmd_err       = err_reg;
  assign o_cmd_data      = rdata_reg;

  // State register, command latch, latency counter and completion result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      write_reg    <= 1'b0;
      cccr_sel_reg <= 1'b0;
      fbr_sel_reg  <= '0;
      cis_sel_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
`ifdef SDIO_CIA_RAW_EN
      raw_reg      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && i_cmd_stb) begin
        write_reg    <= i_cmd_write;
        cccr_sel_reg <= dec_cccr;
        fbr_sel_reg  <= dec_fbr;
        cis_sel_reg  <= dec_cis;
        addr_reg     <= dec_offset;
        wdata_reg    <= i_cmd_data;
`ifdef SDIO_CIA_RAW_EN
        raw_reg      <= i_cmd_raw;
`endif
        if (dec_err) begin
          err_reg   <= 1'b1;
          rdata_reg <= 8'h00;
        end
      end
      // Each strobe restarts the latency countdown
      if (o_tgt_stb) wait_cnt_reg <= WAIT_INIT;
      else if (wait_cnt_reg != 2'd0) wait_cnt_reg <= wait_cnt_reg - 2'd1;
      // Plain write completes straight from ISSUE with no read-back
      if (state_reg == ST_ISSUE && state_next == ST_DONE) begin
        err_reg   <= 1'b0;
        rdata_reg <= 8'h00;
      end
      if (capture) begin
        err_reg   <= 1'b0;
        rdata_reg <= tgt_rdata;
      end
    end
  end

endmodule
